md_unit: RTL and testbench

// - Parametrised multi-cycle divide unit that produces HI/LO; successor to the single-cycle divide path in the execute stage.
// - Sits beside the execute stage. The hazard unit stalls MFHI/MFLO and a new DIV while busy=1.
// - On done, the writeback logic commits hi/lo to the HI/LO registers.
// - Adds signed/unsigned mode, flush abort, a defined divide-by-zero result and an optional multiply.

---
 rtl/md_unit_if.sv | 32 +++
 rtl/md_unit.sv | 182 ++++++++++++++++++
 tb/tb_md_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_if
// Description : Request/result bundle between the execute stage and md_unit.
// Revision    : 1.0  initial release
// ============================================================================
interface md_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_signed;
  logic             op_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op_signed, op_div, a, b, flush,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op_signed, op_div, a, b, flush,
    output busy, done, hi, lo, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle restoring divider producing HI/LO, fixed latency.
//               Define MDU_MULT_EN to add a shift-add multiply (op_div=0).
// Revision    : 1.0  initial release
// ============================================================================
module md_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic clock,
  input  wire logic reset_n,
  md_unit_if.slave  bus
);
  localparam int c_cntW = $clog2(WIDTH) + 1;
  localparam logic [c_cntW-1:0] c_lastStep = c_cntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [c_cntW-1:0]   r_count;
  logic [WIDTH-1:0]    r_rem;
  logic [WIDTH-1:0]    r_quot;
  logic [WIDTH-1:0]    r_operand;
  logic [WIDTH-1:0]    r_aRaw;
  logic                r_negQ;
  logic                r_negR;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic                r_dbz;
`ifdef MDU_MULT_EN
  logic                r_opDiv;
  logic [WIDTH:0]      w_addSum;
  logic [2*WIDTH-1:0]  w_prod;
`endif

  logic                w_canStart;
  logic                w_opOk;
  logic                w_accept;
  logic                w_aNeg;
  logic                w_bNeg;
  logic [WIDTH-1:0]    w_aMag;
  logic [WIDTH-1:0]    w_bMag;
  logic [WIDTH:0]      w_remShift;
  logic [WIDTH:0]      w_diff;
  logic [WIDTH-1:0]    w_stepRem;
  logic [WIDTH-1:0]    w_stepQuot;
  logic [WIDTH-1:0]    w_fixHi;
  logic [WIDTH-1:0]    w_fixLo;
  logic                w_fixDbz;

  assign w_canStart = (r_state == IDLE) || (r_state == DONE);
`ifdef MDU_MULT_EN
  assign w_opOk     = 1'b1;
`else
  assign w_opOk     = bus.op_div;
`endif
  assign w_accept   = bus.start & ~bus.flush & w_canStart & w_opOk;

  assign w_aNeg = bus.op_signed & bus.a[WIDTH-1];
  assign w_bNeg = bus.op_signed & bus.b[WIDTH-1];
  assign w_aMag = w_aNeg ? -bus.a : bus.a;
  assign w_bMag = w_bNeg ? -bus.b : bus.b;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // flush outranks everything, including a start on the same edge
  always_comb begin
    w_nextState = r_state;
    if (bus.flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_nextState = RUN;
        RUN:     if (r_count == c_lastStep) w_nextState = FIX;
        FIX:     w_nextState = DONE;
        DONE:    w_nextState = w_accept ? RUN : IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // One restoring step: shift {rem,quot} left, keep the trial difference if non-negative
  assign w_remShift = {r_rem, r_quot[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_operand};
`ifdef MDU_MULT_EN
  assign w_addSum   = {1'b0, r_rem} + (r_quot[0] ? {1'b0, r_operand} : {(WIDTH+1){1'b0}});
`endif

  always_comb begin
    w_stepRem  = w_diff[WIDTH] ? w_remShift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    w_stepQuot = {r_quot[WIDTH-2:0], ~w_diff[WIDTH]};
`ifdef MDU_MULT_EN
    if (!r_opDiv) begin
      w_stepRem  = w_addSum[WIDTH:1];
      w_stepQuot = {w_addSum[0], r_quot[WIDTH-1:1]};
    end
`endif
  end

  always_comb begin
    w_fixHi  = r_negR ? -r_rem  : r_rem;
    w_fixLo  = r_negQ ? -r_quot : r_quot;
    w_fixDbz = 1'b0;
    if (r_operand == '0) begin
      w_fixHi  = r_aRaw;
      w_fixLo  = '1;
      w_fixDbz = 1'b1;
    end
`ifdef MDU_MULT_EN
    w_prod = r_negQ ? -{r_rem, r_quot} : {r_rem, r_quot};
    if (!r_opDiv) begin
      w_fixHi  = w_prod[2*WIDTH-1:WIDTH];
      w_fixLo  = w_prod[WIDTH-1:0];
      w_fixDbz = 1'b0;
    end
`endif
  end

  // For multiply the multiplicand sits in r_operand and the multiplier in r_quot
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_operand <= '0;
      r_aRaw    <= '0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_dbz     <= 1'b0;
`ifdef MDU_MULT_EN
      r_opDiv   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_count <= '0;
      r_rem   <= '0;
      r_aRaw  <= bus.a;
      r_negQ  <= w_aNeg ^ w_bNeg;
      r_negR  <= w_aNeg;
`ifdef MDU_MULT_EN
      r_opDiv   <= bus.op_div;
      r_operand <= bus.op_div ? w_bMag : w_aMag;
      r_quot    <= bus.op_div ? w_aMag : w_bMag;
`else
      r_operand <= w_bMag;
      r_quot    <= w_aMag;
`endif
    end else if (!bus.flush) begin
      if (r_state == RUN) begin
        r_rem   <= w_stepRem;
        r_quot  <= w_stepQuot;
        r_count <= r_count + c_cntW'(1);
      end
      if (r_state == FIX) begin
        r_hi  <= w_fixHi;
        r_lo  <= w_fixLo;
        r_dbz <= w_fixDbz;
      end
    end
  end

  assign bus.busy        = (r_state == RUN) || (r_state == FIX);
  assign bus.done        = (r_state == DONE);
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Directed self-checking bench for md_unit (WIDTH=32).
// Revision    : 1.0  initial release
// ============================================================================
module tb_md_unit;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  md_unit_if #(.WIDTH(W)) bus ();

  md_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic startOp(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sg, input logic dv);
    bus.a         = av;
    bus.b         = bv;
    bus.op_signed = sg;
    bus.op_div    = dv;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic waitDone(output int busyCyc, output bit got);
    busyCyc = 0;
    got     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (bus.busy) busyCyc++;
      tick();
    end
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sg, input logic dv,
                       input logic [W-1:0] expHi, input logic [W-1:0] expLo, input logic expDbz);
    int busyCyc;
    bit got;
    startOp(av, bv, sg, dv);
    waitDone(busyCyc, got);
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(busyCyc), 64'd33);
    chk({tag, "_hi"}, 64'(bus.hi), 64'(expHi));
    chk({tag, "_lo"}, 64'(bus.lo), 64'(expLo));
    chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(expDbz));
    tick();
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int  busyCyc;
    bit  got;
    bit  sawDone;

    reset_n       = 1'b0;
    bus.start     = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_div    = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.flush     = 1'b0;
    #12;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    reset_n = 1'b1;
    tick();

    runOp("u100_7", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 32'd14, 1'b0);
    runOp("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
    runOp("dbz", 32'h0000_1234, 32'd0, 1'b0, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);

    // back-to-back: start raised in the DONE cycle
    startOp(32'd100, 32'd7, 1'b0, 1'b1);
    waitDone(busyCyc, got);
    chk("b2b_first_done", 64'(got), 64'd1);
    bus.a = 32'd9; bus.b = 32'd4; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    waitDone(busyCyc, got);
    chk("b2b_done", 64'(got), 64'd1);
    chk("b2b_cycles", 64'(busyCyc), 64'd33);
    chk("b2b_hi", 64'(bus.hi), 64'd1);
    chk("b2b_lo", 64'(bus.lo), 64'd2);
    tick();

    // flush during the 10th RUN cycle
    startOp(32'd100, 32'd7, 1'b0, 1'b1);
    repeat (9) tick();
    chk("run_hold_hi", 64'(bus.hi), 64'd1);
    chk("run_hold_lo", 64'(bus.lo), 64'd2);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 64'(bus.busy), 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) sawDone = 1'b1;
      tick();
    end
    chk("flush_no_done", 64'(sawDone), 64'd0);
    chk("flush_hi", 64'(bus.hi), 64'd1);
    chk("flush_lo", 64'(bus.lo), 64'd2);
    runOp("u50_5", 32'd50, 32'd5, 1'b0, 1'b1, 32'd0, 32'd10, 1'b0);

    // flush and start on the same edge
    bus.a = 32'd9; bus.b = 32'd4; bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_beats_start", 64'(bus.busy), 64'd0);
    tick();
    chk("flush_beats_start_idle", 64'(bus.busy), 64'd0);

    // start while busy must not re-latch operands
    startOp(32'd100, 32'd7, 1'b0, 1'b1);
    repeat (5) tick();
    bus.a = 32'd50; bus.b = 32'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    waitDone(busyCyc, got);
    chk("ign_start_done", 64'(got), 64'd1);
    chk("ign_start_cycles", 64'(busyCyc), 64'd27);
    chk("ign_start_hi", 64'(bus.hi), 64'd2);
    chk("ign_start_lo", 64'(bus.lo), 64'd14);
    tick();

`ifdef MDU_MULT_EN
    runOp("mul_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd1, 1'b0);
    runOp("mul_s", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 32'd1, 1'b0);
    runOp("mul_u2", 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd700, 1'b0);
`else
    startOp(32'd3, 32'd5, 1'b0, 1'b0);
    chk("mul_off_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("mul_off_done", 64'(bus.done), 64'd0);
    chk("mul_off_lo", 64'(bus.lo), 64'd14);
`endif

    // asynchronous reset in the middle of RUN
    runOp("u9_4", 32'd9, 32'd4, 1'b0, 1'b1, 32'd1, 32'd2, 1'b0);
    startOp(32'd100, 32'd7, 1'b0, 1'b1);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("midrst_idle", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
